// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and index-width derivation for the branch predictor
package bp_pkg;

  function automatic int idx_width(input int entries);
    int w;
    w = 0;
    while ((1 << w) < entries) w++;
    return w;
  endfunction

  function automatic int cnt_strong_not_taken(input int cnt_w);
    return 0;
  endfunction

  function automatic int cnt_weak_not_taken(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic int cnt_weak_taken(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int cnt_strong_taken(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down counter for one predictor entry
module sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(cnt_strong_not_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_strong_taken(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cnt_weak_not_taken(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cnt_weak_taken(CNT_W));

  // clr together with inc loads weakly-taken: that is how a fresh allocation seeds the entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= WEAK_NT;
    end else if (clr) begin
      value <= inc ? WEAK_T : WEAK_NT;
    end else if (inc && !dec && value != CNT_MAX) begin
      value <= value + CNT_W'(1);
    end else if (dec && !inc && value != CNT_MIN) begin
      value <= value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch target buffer with saturating direction counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_hit,
  output logic              o_predict_taken,
  output logic [ADDR_W-1:0] o_predict_target,
  input  logic              i_update_valid,
  input  logic [ADDR_W-1:0] i_update_pc,
  input  logic              i_update_taken,
  input  logic [ADDR_W-1:0] i_update_target,
  input  logic              i_update_pred_taken,
  input  logic [ADDR_W-1:0] i_update_pred_target,
  output logic [31:0]       o_update_count,
  output logic [31:0]       o_mispredict_count
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt      [ENTRIES];

  logic [ENTRIES-1:0] cnt_inc;
  logic [ENTRIES-1:0] cnt_dec;
  logic [ENTRIES-1:0] cnt_clr;

  logic [31:0] update_cnt_q;
  logic [31:0] mispredict_cnt_q;

  // lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx = i_pc[IDX_W+1:2];
  assign lk_tag = i_pc[ADDR_W-1:IDX_W+2];

  always_comb begin
    o_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    o_predict_taken  = 1'b0;
    o_predict_target = '0;
    if (o_hit) begin
      o_predict_taken  = cnt[lk_idx][CNT_W-1];
      o_predict_target = target_q[lk_idx];
    end
  end

  // update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_apply;
  logic             up_alloc;
  logic             mispredict;

  assign up_idx   = i_update_pc[IDX_W+1:2];
  assign up_tag   = i_update_pc[ADDR_W-1:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_apply = i_update_valid && !i_clear;
  assign up_alloc = up_apply && !up_hit && i_update_taken;

  assign mispredict = i_update_valid &&
                      ((i_update_pred_taken != i_update_taken) ||
                       (i_update_taken && i_update_pred_taken &&
                        (i_update_pred_target != i_update_target)));

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    cnt_clr = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_clear) begin
        cnt_clr[i] = 1'b1;
      end else if (up_apply && up_idx == IDX_W'(i)) begin
        cnt_inc[i] = i_update_taken && (up_hit || up_alloc);
        cnt_dec[i] = up_hit && !i_update_taken;
        cnt_clr[i] = up_alloc;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[g]),
      .dec   (cnt_dec[g]),
      .clr   (cnt_clr[g]),
      .value (cnt[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (i_clear) begin
      valid_q <= '0;
    end else if (up_apply && i_update_taken) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= i_update_target;
    end
  end

  // statistics ignore i_clear so a cleared update is still counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (i_update_valid) update_cnt_q <= update_cnt_q + 32'd1;
      if (mispredict)     mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign o_update_count     = update_cnt_q;
  assign o_mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks of branch_predictor against a table model
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int WEAK_T  = 1 << (CNT_W - 1);

  logic              clk;
  logic              reset;
  logic              i_clear;
  logic [ADDR_W-1:0] i_pc;
  logic              o_hit;
  logic              o_predict_taken;
  logic [ADDR_W-1:0] o_predict_target;
  logic              i_update_valid;
  logic [ADDR_W-1:0] i_update_pc;
  logic              i_update_taken;
  logic [ADDR_W-1:0] i_update_target;
  logic              i_update_pred_taken;
  logic [ADDR_W-1:0] i_update_pred_target;
  logic [31:0]       o_update_count;
  logic [31:0]       o_mispredict_count;

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_clear              (i_clear),
    .i_pc                 (i_pc),
    .o_hit                (o_hit),
    .o_predict_taken      (o_predict_taken),
    .o_predict_target     (o_predict_target),
    .i_update_valid       (i_update_valid),
    .i_update_pc          (i_update_pc),
    .i_update_taken       (i_update_taken),
    .i_update_target      (i_update_target),
    .i_update_pred_taken  (i_update_pred_taken),
    .i_update_pred_target (i_update_pred_target),
    .o_update_count       (o_update_count),
    .o_mispredict_count   (o_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model: one record per entry, counter kept as a plain integer
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_upd;
  logic [31:0] m_mis;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_cnt[i]   = WEAK_T - 1;
    end
    m_upd = '0;
    m_mis = '0;
  endtask

  task automatic check_lookup();
    int          idx;
    bit          hit;
    idx = m_index(i_pc);
    hit = m_valid[idx] && (m_tag[idx] == m_tagof(i_pc));
    chk("hit", 32'(o_hit), 32'(hit));
    chk("predict_taken", 32'(o_predict_taken), 32'(hit && m_cnt[idx] >= WEAK_T));
    chk("predict_target", o_predict_target, hit ? m_tgt[idx] : 32'h0);
    chk("update_count", o_update_count, m_upd);
    chk("mispredict_count", o_mispredict_count, m_mis);
  endtask

  task automatic model_apply();
    int idx;
    bit hit;
    if (i_update_valid) begin
      m_upd = m_upd + 32'd1;
      if ((i_update_pred_taken != i_update_taken) ||
          (i_update_taken && i_update_pred_target != i_update_target))
        m_mis = m_mis + 32'd1;
    end
    if (i_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_cnt[i]   = WEAK_T - 1;
      end
    end else if (i_update_valid) begin
      idx = m_index(i_update_pc);
      hit = m_valid[idx] && (m_tag[idx] == m_tagof(i_update_pc));
      if (hit) begin
        if (i_update_taken) begin
          m_cnt[idx] = (m_cnt[idx] < CNT_MAX) ? m_cnt[idx] + 1 : CNT_MAX;
          m_tgt[idx] = i_update_target;
        end else begin
          m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
        end
      end else if (i_update_taken) begin
        m_valid[idx] = 1;
        m_tag[idx]   = m_tagof(i_update_pc);
        m_tgt[idx]   = i_update_target;
        m_cnt[idx]   = WEAK_T;
      end
    end
  endtask

  // called at a negedge: check the lookup, clock once, advance the model, back to negedge
  task automatic cycle();
    #1 check_lookup();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
    i_update_valid       = 1'b1;
    i_update_pc          = pc;
    i_update_taken       = tk;
    i_update_target      = tgt;
    i_update_pred_taken  = ptk;
    i_update_pred_target = ptgt;
  endtask

  task automatic idle();
    i_update_valid = 1'b0;
    i_clear        = 1'b0;
  endtask

  logic [31:0] rpc;
  logic [31:0] rtgt;
  logic [31:0] mis_before;

  initial begin
    reset = 1'b0;
    i_clear = 1'b0;
    i_pc = 32'h0040_0000;
    drive_upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    i_update_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_lookup();
    @(negedge clk);
    reset = 1'b1;

    // lookup after reset release
    i_pc = 32'h0040_0000;
    #1;
    chk("rst_hit", 32'(o_hit), 32'h0);
    chk("rst_taken", 32'(o_predict_taken), 32'h0);
    chk("rst_target", o_predict_target, 32'h0);
    chk("rst_upd_cnt", o_update_count, 32'h0);
    chk("rst_mis_cnt", o_mispredict_count, 32'h0);
    @(negedge clk);

    // allocate on taken miss
    i_pc = 32'h0040_0010;
    drive_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
    cycle();
    idle();
    #1;
    chk("alloc_hit", 32'(o_hit), 32'h1);
    chk("alloc_taken", 32'(o_predict_taken), 32'h1);
    chk("alloc_target", o_predict_target, 32'h0040_0040);
    @(negedge clk);

    // four not-taken updates: counter walks down and saturates at 0
    for (int k = 0; k < 4; k++) begin
      drive_upd(32'h0040_0010, 1'b0, 32'h0, (k == 0), 32'h0040_0040);
      cycle();
      idle();
      #1;
      chk("nt_taken", 32'(o_predict_taken), 32'h0);
      chk("nt_hit", 32'(o_hit), 32'h1);
      @(negedge clk);
    end
    drive_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040);
    cycle();
    idle();
    #1 chk("sat_floor_taken", 32'(o_predict_taken), 32'h0);
    @(negedge clk);

    // aliasing on one index
    drive_upd(32'h0040_0010, 1'b1, 32'h0040_0044, 1'b0, 32'h0);
    cycle();
    drive_upd(32'h0040_0050, 1'b1, 32'h0040_0080, 1'b0, 32'h0);
    cycle();
    idle();
    i_pc = 32'h0040_0010;
    #1 chk("alias_old_hit", 32'(o_hit), 32'h0);
    i_pc = 32'h0040_0050;
    #1 chk("alias_new_hit", 32'(o_hit), 32'h1);
    chk("alias_new_target", o_predict_target, 32'h0040_0080);
    @(negedge clk);

    // target-only misprediction
    mis_before = m_mis;
    drive_upd(32'h0000_0100, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);
    cycle();
    idle();
    #1 chk("mis_target", o_mispredict_count, mis_before + 32'd1);
    @(negedge clk);

    // clear wins over a concurrent update, which is still counted
    i_clear = 1'b1;
    drive_upd(32'h0040_0050, 1'b1, 32'h0040_0090, 1'b1, 32'h0040_0080);
    cycle();
    idle();
    i_pc = 32'h0040_0050;
    #1 chk("clear_hit", 32'(o_hit), 32'h0);
    chk("clear_upd_cnt", o_update_count, m_upd);
    @(negedge clk);

    // wrap of the update counter
    force dut.update_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.update_cnt_q;
    m_upd = 32'hFFFF_FFFF;
    #1 chk("preload_upd_cnt", o_update_count, 32'hFFFF_FFFF);
    @(negedge clk);
    drive_upd(32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    idle();
    #1 chk("wrap_upd_cnt", o_update_count, 32'h0);
    @(negedge clk);

    // randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 400; n++) begin
      rpc  = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2);
      rtgt = 32'h0050_0000 | ($urandom_range(0, 7) << 2);
      i_clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) != 0)
        drive_upd(rpc, 1'($urandom_range(0, 1)), rtgt, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? rtgt : 32'h0050_0000);
      else
        i_update_valid = 1'b0;
      i_pc = ($urandom_range(0, 1) != 0) ? rpc
             : (32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2));
      cycle();
    end
    idle();

    // populate, then assert reset mid-stream with an update in flight
    drive_upd(32'h0040_0030, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    cycle();
    drive_upd(32'h0040_0070, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    i_pc = 32'h0040_0030;
    #2 reset = 1'b0;
    #1;
    chk("midrst_hit", 32'(o_hit), 32'h0);
    chk("midrst_taken", 32'(o_predict_taken), 32'h0);
    chk("midrst_target", o_predict_target, 32'h0);
    chk("midrst_upd_cnt", o_update_count, 32'h0);
    chk("midrst_mis_cnt", o_mispredict_count, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    reset = 1'b1;
    i_pc = 32'h0040_0070;
    #1 chk("post_rst_hit", 32'(o_hit), 32'h0);
    @(negedge clk);
    drive_upd(32'h0040_0070, 1'b0, 32'h0, 1'b1, 32'h0040_0200);
    cycle();
    idle();
    #1 chk("post_rst_nt_miss", 32'(o_hit), 32'h0);
    @(negedge clk);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
